if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_stage_if_id_reg.sv | 28 ++
 rtl/if_stage.sv | 91 +++++++++
 tb/tb_if_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared CPU constants for the fetch stage: NOP encoding, PC width/increment,
// instruction-memory depth and the IF/ID register payload type.
package if_stage_pkg;

    localparam int          PC_W      = 32;
    localparam logic [31:0] NOP       = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;
    localparam int          IM_LENGTH = 1024;

    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pc_plus4;
        logic [31:0]       instr;
    } if_id_t;

    localparam if_id_t BUBBLE = '{valid: 1'b0, pc: '0, pc_plus4: '0, instr: NOP};

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats hold, hold beats load; resets to a bubble.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   hold,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BUBBLE;
        end else if (bubble) begin
            q <= BUBBLE;
        end else if (hold) begin
            q <= q;
        end else if (load) begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // register samples pre-edge values regardless of process ordering.
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC mux and IF/ID register.
// Optional performance counters are enabled with the IF_PERF_CNT_EN macro.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_AW    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [IM_AW-1:0] imem_addr,
    input  logic [31:0]      imem_instr,
    output logic [31:0]      pc,
    output logic             id_valid,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc_plus4,
    output logic [31:0]      id_instr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);

    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] next_pc;
    logic            id_bubble;
    logic            id_load;
    if_id_t          id_d;
    if_id_t          id_q;
    logic            unused_redirect_lsb;

    // Word-aligned target; the low redirect bits are intentionally dropped.
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign pc_plus4  = pc + PC_INC;
    assign imem_addr = pc[IM_AW+1:2];

    always_comb begin
        next_pc = pc_plus4;
        if (redirect_valid) begin
            next_pc = {redirect_pc[31:2], 2'b00};
        end else if (stall) begin
            next_pc = pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    assign id_bubble = redirect_valid | flush;
    assign id_load   = !id_bubble && !stall;
    assign id_d      = '{valid: 1'b1, pc: pc, pc_plus4: pc_plus4, instr: imem_instr};

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (id_load),
        .hold   (stall),
        .bubble (id_bubble),
        .d      (id_d),
        .q      (id_q)
    );

    assign id_valid    = id_q.valid;
    assign id_pc       = id_q.pc;
    assign id_pc_plus4 = id_q.pc_plus4;
    assign id_instr    = id_q.instr;

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (id_load) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall && !redirect_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: driver pushes hand-computed post-edge state,
// monitor pops and compares one entry per clock edge.
module tb_if_stage;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic        v;
        logic [31:0] ipc;
        logic [31:0] ip4;
        logic [31:0] instr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [9:0]  imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    logic [31:0] mem [0:1023];
    vec_t        sb[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr];

    if_stage #(.RESET_PC(32'h0000_0000), .IM_AW(10)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .pc             (pc),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_instr       (id_instr)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic f, input logic r, input logic [31:0] rp,
                                input logic [31:0] epc, input logic ev, input logic [31:0] eipc,
                                input logic [31:0] eip4, input logic [31:0] ein);
        vec_t t;
        t.stall = s; t.flush = f; t.rv = r; t.rpc = rp;
        t.pc = epc; t.v = ev; t.ipc = eipc; t.ip4 = eip4; t.instr = ein;
        return t;
    endfunction

    // Drive one vector (caller is at a negedge) and advance to the next negedge.
    task automatic apply(input vec_t t);
        stall = t.stall;
        flush = t.flush;
        redirect_valid = t.rv;
        redirect_pc = t.rpc;
        sb.push_back(t);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            vec_t e;
            logic [31:0] exp_addr;
            e = sb.pop_front();
            exp_addr = {22'd0, e.pc[11:2]};
            check("pc", pc, e.pc);
            check("imem_addr", {22'd0, imem_addr}, exp_addr);
            check("id_valid", {31'd0, id_valid}, {31'd0, e.v});
            check("id_pc", id_pc, e.ipc);
            check("id_pc_plus4", id_pc_plus4, e.ip4);
            check("id_instr", id_instr, e.instr);
        end
    end

    vec_t vecs[$];
    vec_t post_rst[$];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h2001_0005;

        // stall flush rv rpc            pc            v  id_pc         id_pc_plus4   id_instr
        vecs = '{
            mk(0, 0, 0, 32'h0,         32'h0000_0004, 1, 32'h0000_0000, 32'h0000_0004, 32'h2001_0005),
            mk(0, 0, 0, 32'h0,         32'h0000_0008, 1, 32'h0000_0004, 32'h0000_0008, 32'h1000_0001),
            mk(0, 0, 0, 32'h0,         32'h0000_000C, 1, 32'h0000_0008, 32'h0000_000C, 32'h1000_0002),
            mk(0, 0, 0, 32'h0,         32'h0000_0010, 1, 32'h0000_000C, 32'h0000_0010, 32'h1000_0003),
            mk(1, 0, 0, 32'h0,         32'h0000_0010, 1, 32'h0000_000C, 32'h0000_0010, 32'h1000_0003),
            mk(1, 0, 0, 32'h0,         32'h0000_0010, 1, 32'h0000_000C, 32'h0000_0010, 32'h1000_0003),
            mk(1, 0, 0, 32'h0,         32'h0000_0010, 1, 32'h0000_000C, 32'h0000_0010, 32'h1000_0003),
            mk(0, 0, 0, 32'h0,         32'h0000_0014, 1, 32'h0000_0010, 32'h0000_0014, 32'h1000_0004),
            mk(0, 0, 0, 32'h0,         32'h0000_0018, 1, 32'h0000_0014, 32'h0000_0018, 32'h1000_0005),
            mk(0, 0, 0, 32'h0,         32'h0000_001C, 1, 32'h0000_0018, 32'h0000_001C, 32'h1000_0006),
            mk(0, 0, 0, 32'h0,         32'h0000_0020, 1, 32'h0000_001C, 32'h0000_0020, 32'h1000_0007),
            mk(0, 1, 0, 32'h0,         32'h0000_0024, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000),
            mk(0, 0, 0, 32'h0,         32'h0000_0028, 1, 32'h0000_0024, 32'h0000_0028, 32'h1000_0009),
            mk(1, 1, 0, 32'h0,         32'h0000_0028, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000),
            mk(1, 0, 1, 32'h0000_0043, 32'h0000_0040, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000),
            mk(0, 0, 0, 32'h0,         32'h0000_0044, 1, 32'h0000_0040, 32'h0000_0044, 32'h1000_0010),
            mk(0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000),
            mk(0, 0, 0, 32'h0,         32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h1000_03FF),
            mk(0, 1, 1, 32'h0000_0100, 32'h0000_0100, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000),
            mk(0, 0, 0, 32'h0,         32'h0000_0104, 1, 32'h0000_0100, 32'h0000_0104, 32'h1000_0040)
        };
        post_rst = '{
            mk(1, 0, 0, 32'h0,         32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000),
            mk(0, 0, 0, 32'h0,         32'h0000_0004, 1, 32'h0000_0000, 32'h0000_0004, 32'h2001_0005)
        };

        repeat (3) @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_id_valid", {31'd0, id_valid}, 32'h0);
        check("rst_id_instr", id_instr, 32'h0);
        check("rst_imem_addr", {22'd0, imem_addr}, 32'h0);

        rst_n = 1'b1;
        foreach (vecs[i]) begin
            apply(vecs[i]);
`ifdef IF_PERF_CNT_EN
            if (i == 6) begin
                check("perf_stall_cnt_after_stall", perf_stall_cnt, 32'd3);
                check("perf_fetch_cnt_after_stall", perf_fetch_cnt, 32'd4);
            end
`endif
        end

        // Reset asserted asynchronously while stall and redirect are both active.
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_id_valid", {31'd0, id_valid}, 32'h0);
        check("async_rst_id_pc", id_pc, 32'h0);
        repeat (2) @(negedge clk);
        check("held_rst_pc", pc, 32'h0);

        rst_n = 1'b1;
        foreach (post_rst[i]) apply(post_rst[i]);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch_cnt_final", perf_fetch_cnt, 32'd1);
        check("perf_stall_cnt_final", perf_stall_cnt, 32'd1);
`endif

        for (int n = 0; n < 20 && sb.size() > 0; n++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
